// File: rtl/return_stack_ctrl.sv
// return_stack_ctrl: call/ret/flush sequencer for an external LIFO; RSC_STICKY_ERR_EN makes overflow/underflow sticky
module return_stack_ctrl #(
  parameter int WIDTH    = 8,
  parameter int CAPACITY = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             call,
  input  logic [WIDTH-1:0] call_addr,
  input  logic             ret,
  input  logic             flush,
  output logic             ready,
  output logic             ret_valid,
  output logic [WIDTH-1:0] ret_addr,
  output logic [CNT_W-1:0] depth,
  output logic             overflow,
  output logic             underflow,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_wdata,
  input  logic [WIDTH-1:0] stk_rdata
);
`ifdef RSC_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif
  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  typedef enum logic [2:0] {IDLE, PUSH, POP, SWAP_PUSH, FLUSH} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] depth_n;
  logic [WIDTH-1:0] ret_addr_n, stk_wdata_n;
  logic ret_valid_n, overflow_n, underflow_n, stk_push_n, stk_pop_n;
  logic empty, full;
  assign empty = depth == '0;
  assign full  = depth == CAP;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ready     <= 1'b1;
      depth     <= '0;
      ret_valid <= 1'b0;
      ret_addr  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      stk_push  <= 1'b0;
      stk_pop   <= 1'b0;
      stk_wdata <= '0;
    end else begin
      state     <= state_n;
      ready     <= state_n == IDLE;
      depth     <= depth_n;
      ret_valid <= ret_valid_n;
      ret_addr  <= ret_addr_n;
      overflow  <= overflow_n;
      underflow <= underflow_n;
      stk_push  <= stk_push_n;
      stk_pop   <= stk_pop_n;
      stk_wdata <= stk_wdata_n;
    end
  end
  always_comb begin
    state_n = IDLE;
    unique case (state)
      IDLE:      state_n = flush ? FLUSH : (call && ret) ? SWAP_PUSH :
                           ret ? (empty ? IDLE : POP) : call ? (full ? IDLE : PUSH) : IDLE;
      SWAP_PUSH: state_n = PUSH;
      FLUSH:     state_n = empty ? IDLE : FLUSH;
      default:   state_n = IDLE;
    endcase
  end
  // the tail-replace address rides in stk_wdata from accept until the SWAP_PUSH strobe
  always_comb begin
    depth_n     = depth;
    ret_addr_n  = ret_addr;
    stk_wdata_n = stk_wdata;
    ret_valid_n = 1'b0;
    stk_push_n  = 1'b0;
    stk_pop_n   = 1'b0;
    overflow_n  = STICKY & overflow;
    underflow_n = STICKY & underflow;
    unique case (state)
      IDLE: begin
        if (flush) begin
          stk_pop_n   = !empty;
          depth_n     = empty ? depth : depth - ONE;
          overflow_n  = 1'b0;
          underflow_n = 1'b0;
        end else if (ret) begin
          underflow_n = empty | underflow_n;
          ret_valid_n = !empty;
          stk_pop_n   = !empty;
          ret_addr_n  = empty ? ret_addr : stk_rdata;
          depth_n     = empty ? depth : depth - ONE;
          stk_wdata_n = call ? call_addr : stk_wdata;
        end else if (call) begin
          overflow_n  = full | overflow_n;
          stk_push_n  = !full;
          stk_wdata_n = full ? stk_wdata : call_addr;
          depth_n     = full ? depth : depth + ONE;
        end
      end
      SWAP_PUSH: begin
        stk_push_n = 1'b1;
        depth_n    = depth + ONE;
      end
      FLUSH: begin
        stk_pop_n = !empty;
        depth_n   = empty ? depth : depth - ONE;
      end
      default: ;
    endcase
  end
endmodule

// File: doc/return_stack_ctrl.md
# return_stack_ctrl

Controller that drives an 8-bit hardware LIFO (push/pop/data_in/data_out interface) from the requesting side. It sits between the MIPS multi-cycle control unit and the stack. It converts call/return/flush requests into correctly sequenced stack push/pop strobes. It tracks occupancy, blocks overflow/underflow, and delivers popped return addresses with a valid pulse.

## Interface
Parameters:
- `WIDTH`, 8, data/address width (matches stack word width)
- `CAPACITY`, 8, number of stack entries usable
- `CNT_W`, 4, width of `depth` (must hold 0..CAPACITY)

Ports:
- `clk` in 1: single clock, all logic on posedge
- `rst` in 1: synchronous, active-high reset
- `call` in 1: push request; `call_addr` is the value pushed
- `call_addr` in WIDTH: return address to push
- `ret` in 1: pop request
- `flush` in 1: empty the stack request
- `ready` out 1: controller accepts a request this cycle
- `ret_valid` out 1: one-cycle pulse, `ret_addr` valid
- `ret_addr` out WIDTH: popped value
- `depth` out CNT_W: current occupancy
- `overflow` out 1: call refused, stack full
- `underflow` out 1: ret refused, stack empty
- `stk_push` out 1: to stack push
- `stk_pop` out 1: to stack pop
- `stk_wdata` out WIDTH: to stack data_in
- `stk_rdata` in WIDTH: from stack data_out (current top, combinational)

## Operation
- States: IDLE, PUSH, POP, SWAP_PUSH, FLUSH. All outputs are registered.
- `ready` = 1 only in IDLE. Requests are sampled only at a posedge with `ready`=1 and are ignored otherwise. The requester holds a request until it sees `ready` high.
- Request priority: `flush` > (`call` & `ret`) > `ret` > `call`.
- **call**, depth < CAPACITY:
  - `stk_wdata`<=`call_addr`, `stk_push`<=1, `depth`+1, go to PUSH.
  - PUSH drops `stk_push` and returns to IDLE.
- **call**, depth == CAPACITY: no push, `overflow` asserted, stay IDLE.
- **ret**, depth > 0:
  - `ret_addr`<=`stk_rdata`, `ret_valid`<=1, `stk_pop`<=1, `depth`-1, go to POP.
  - POP clears `stk_pop` and `ret_valid`, then returns to IDLE.
- **ret**, depth == 0: no pop, `underflow` asserted, `ret_valid` stays 0, `ret_addr` unchanged.
- **call & ret** (tail replace):
  - Performs the ret action, then goes to SWAP_PUSH, which pushes `call_addr` (captured at accept).
  - Net depth is unchanged.
  - If depth == 0: `underflow` asserted, no pop; the push still occurs and depth becomes 1.
- **flush**:
  - Go to FLUSH. Assert `stk_pop` each cycle while depth > 0, decrementing `depth`.
  - Return to IDLE when depth reaches 0. `ret_valid` is never asserted during flush.
  - Flush at depth 0 takes one cycle in FLUSH, with no pop.
- `depth` is authoritative. The controller never issues a pop at depth 0 nor a push at depth CAPACITY.
- Reset values: state IDLE, `ready` 1, `depth` 0, `ret_valid` 0, `ret_addr` 0, `overflow` 0, `underflow` 0, `stk_push` 0, `stk_pop` 0, `stk_wdata` 0.
- `rst` mid-operation aborts any state next edge. Stack contents are abandoned; the integrator must reset the stack pointer alongside.

## Timing
- call: accepted at edge N; `stk_push` high during cycle N..N+1; `ready` low for one cycle. Throughput is one call per 2 cycles.
- ret: accepted at edge N; `ret_addr`/`ret_valid`/`stk_pop` high during cycle N..N+1. Latency is 1 cycle.
- call & ret: `stk_pop` in cycle after N, `stk_push` in the following cycle; `ready` low for 2 cycles.
- flush from depth D: `ready` low for max(D,1) cycles.
- `stk_push` and `stk_pop` are never high in the same cycle.

## Configuration
- `RSC_STICKY_ERR_EN`:
  - Defined: `overflow`/`underflow` are sticky, set on the event and cleared only by `rst` or `flush` acceptance.
  - Undefined: each is a one-cycle pulse in the cycle after the refused request.

## Test plan
- Reset, then 3 calls (0x10, 0x20, 0x30), then 3 rets -> `ret_addr` 0x30, 0x20, 0x10 with `ret_valid` pulses; depth 3 -> 0.
- Fill to depth 8, then call 0x55 -> no `stk_push`, `overflow` high, depth stays 8.
- ret at depth 0 -> no `stk_pop`, `underflow` high, `ret_valid` 0. Check both macro settings (pulse vs. held until flush).
- depth 2 (top 0x22), call 0x77 with ret -> `ret_addr` 0x22, pop then push; depth 2; next ret returns 0x77.
- depth 5, flush -> 5 consecutive `stk_pop` cycles, `ready` low 5 cycles, depth 0, no `ret_valid`.
- `rst` asserted during FLUSH at depth 3 -> all outputs at reset values next cycle; `ready` 1, depth 0.
